// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/write-back
// sequencing, a bounded data-memory wait, sticky halt/fault states and a retire counter.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opecode,
   input  logic [5:0]       funct,
   input  logic             imem_valid,
   input  logic             dmem_ready,
   output logic             pc_we,
   output logic             ir_we,
   output logic             reg_we,
   output logic             alusrc,
   output logic             zors,
   output logic             mem_re,
   output logic             mem_we,
   output logic             branch,
   output logic             jump,
   output logic [2:0]       state,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5,
      FAULT  = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CL_RTYPE, CL_ADDI, CL_LOGIC_IMM, CL_LW, CL_SW, CL_BEQ, CL_JUMP, CL_HALT, CL_BAD
   } class_t;

   function automatic class_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00:   classify = (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})
                             ? CL_RTYPE : CL_BAD;
         6'h08:   classify = CL_ADDI;
         6'h0C,
         6'h0D:   classify = CL_LOGIC_IMM;
         6'h23:   classify = CL_LW;
         6'h2B:   classify = CL_SW;
         6'h04:   classify = CL_BEQ;
         6'h02:   classify = CL_JUMP;
         6'h3F:   classify = CL_HALT;
         default: classify = CL_BAD;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [5:0]         op_q, funct_q;
   logic [CNT_W-1:0]   retired_q;
   class_t             cls;

   // Everything after DECODE works from the latched instruction, not the live inputs.
   assign cls = classify(op_q, funct_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         op_q      <= '0;
         funct_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (state_q == DECODE) begin
            op_q    <= opecode;
            funct_q <= funct;
         end
         if (pc_we) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      branch  = 1'b0;
      jump    = 1'b0;
      case (state_q)
         FETCH: begin
            if (imem_valid) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            case (classify(opecode, funct))
               CL_HALT: state_d = HALT;
               CL_BAD:  state_d = FAULT;
               default: state_d = EXEC;
            endcase
         end
         EXEC: begin
            case (cls)
               CL_RTYPE, CL_ADDI, CL_LOGIC_IMM: state_d = WB;
               CL_LW, CL_SW:                    state_d = MEM;
               CL_BEQ: begin
                  pc_we   = 1'b1;
                  branch  = 1'b1;
                  state_d = FETCH;
               end
               CL_JUMP: begin
                  pc_we   = 1'b1;
                  jump    = 1'b1;
                  state_d = FETCH;
               end
               default: state_d = FAULT;
            endcase
         end
         MEM: begin
            mem_re = (cls == CL_LW);
            mem_we = (cls == CL_SW);
            // A ready in the final allowed cycle still completes the access.
            if (dmem_ready) begin
               if (cls == CL_LW) begin
                  state_d = WB;
               end else begin
                  pc_we   = 1'b1;
                  state_d = FETCH;
               end
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d = FAULT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WB: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
      // Reset abandons whatever is in flight without emitting any strobe.
      if (rst) begin
         pc_we  = 1'b0;
         ir_we  = 1'b0;
         reg_we = 1'b0;
         mem_re = 1'b0;
         mem_we = 1'b0;
         branch = 1'b0;
         jump   = 1'b0;
      end
   end

   assign alusrc  = (state_q inside {EXEC, MEM, WB}) &&
                    (cls inside {CL_ADDI, CL_LOGIC_IMM, CL_LW, CL_SW});
   assign zors    = (cls != CL_LOGIC_IMM);
   assign state   = state_q;
   assign halted  = (state_q == HALT);
   assign fault   = (state_q == FAULT);
   assign retired = retired_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum MEM-state cycles without dmem_ready before FAULT.
REQ-002 SHALL have parameter CNT_W, default 32: width of retired.
REQ-003 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port opecode  in  6  decoded instruction opcode.
REQ-006 SHALL have port funct  in  6  decoded R-type function field.
REQ-007 SHALL have port imem_valid  in  1  instruction word valid this cycle.
REQ-008 SHALL have port dmem_ready  in  1  data memory access complete this cycle.
REQ-009 SHALL have port pc_we  out  1  PC register write enable.
REQ-010 SHALL have port ir_we  out  1  instruction register write enable.
REQ-011 SHALL have port reg_we  out  1  register file write enable.
REQ-012 SHALL have port alusrc  out  1  ALU B operand select: 0 = rt data, 1 = extended immediate.
REQ-013 SHALL have port zors  out  1  immediate extension: 1 = sign, 0 = zero.
REQ-014 SHALL have ports mem_re and mem_we  out  1 each  data memory read and write strobes.
REQ-015 SHALL have ports branch and jump  out  1 each  PC-source selects, qualified by pc_we.
REQ-016 SHALL have port state  out  3  current FSM state.
REQ-017 SHALL have ports halted and fault  out  1 each  sticky status flags.
REQ-018 SHALL have port retired  out  CNT_W  retired-instruction count.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 unreachable and maps to FAULT on the next edge.
REQ-020 FETCH SHALL hold until imem_valid=1, assert ir_we in that same cycle, then go to DECODE.
REQ-021 DECODE SHALL register opecode and funct internally; later input changes SHALL NOT affect the instruction in flight.
REQ-022 DECODE SHALL classify the instruction and transition as follows.
- opecode 0x00 with funct in {0x20,0x22,0x24,0x25,0x2A,0x00,0x02}: R-type, go to EXEC.
- 0x08 addi, 0x0C andi, 0x0D ori, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j: go to EXEC.
- 0x3F: go to HALT.
- Any other opecode, or opecode 0x00 with any other funct: go to FAULT.
REQ-023 alusrc=1 SHALL hold for addi, andi, ori, lw and sw in EXEC, MEM and WB, and be 0 otherwise.
REQ-024 zors=0 SHALL hold for andi and ori, and zors=1 otherwise.
REQ-025 EXEC SHALL transition by class.
- R-type and I-ALU: go to WB.
- lw and sw: go to MEM.
- beq: assert pc_we and branch, go to FETCH.
- j: assert pc_we and jump, go to FETCH.
REQ-026 MEM SHALL hold mem_re (lw) or mem_we (sw) high continuously until dmem_ready=1.
- lw: go to WB.
- sw: assert pc_we, go to FETCH.
REQ-027 A wait counter SHALL count MEM cycles with dmem_ready=0 and clear on leaving MEM.
- The MEM_TIMEOUT-th consecutive such cycle SHALL go to FAULT with no write issued.
- dmem_ready=1 in that same cycle SHALL take priority over the timeout.
REQ-028 WB SHALL assert reg_we and pc_we for one cycle, then go to FETCH.
REQ-029 Each cycle in which pc_we=1 SHALL increment retired by 1, wrapping from 2^CNT_W-1 to 0.
REQ-030 Latency with imem_valid and dmem_ready both tied high SHALL be as follows.
- R-type and I-ALU: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- beq and j: 3 cycles.
REQ-031 HALT and FAULT SHALL be absorbing states that leave only on reset.
- halted=1 in HALT, fault=1 in FAULT.
- All strobes SHALL be 0 and retired SHALL stay frozen in both states.
REQ-032 pc_we, ir_we, reg_we, mem_re, mem_we, branch and jump SHALL be 0 in every state/condition not listed above.

Reset
REQ-033 rst=1 SHALL take priority over every transition, from any state including mid-MEM.
REQ-034 On reset the next state SHALL be FETCH, with retired=0, wait counter=0, halted=0, fault=0 and all strobes 0 in the cycle after the reset edge.
REQ-035 An in-flight memory access or write-back SHALL be abandoned on reset without emitting reg_we or pc_we.

Verification
REQ-036 Reset, then add (0x00/0x20) with imem_valid=1 -> states 0,1,2,4; reg_we=1 and pc_we=1 in cycle 4; retired=1.
REQ-037 lw (0x23), dmem_ready low for 3 cycles -> mem_re high 4 cycles, then WB; total 8 cycles; alusrc=1, zors=1.
REQ-038 sw (0x2B), dmem_ready never asserted, MEM_TIMEOUT=16 -> FAULT after 16 MEM cycles, fault=1, mem_we=0, retired unchanged.
REQ-039 Sequence ori, beq, 0x3F -> zors=0 for ori; branch=1 with pc_we=1 for beq; halted=1; retired=2 and frozen.
REQ-040 Assert rst during MEM of lw -> next cycle state=0, retired=0, no reg_we pulse.
REQ-041 Preload retired=0xFFFFFFFF by running a 2^32-instruction loop or by a forced override, then retire one instruction -> retired=0.
